// File: rtl/post_process_packer_if.sv
// Stream bundle for post_process_packer: capture controls, sample input,
// packed-word output stream and status/debug signals.
interface post_process_packer_if #(
  parameter int NUM_CH       = 3,
  parameter int SAMPLE_WIDTH = 16
);
  logic                           start;
  logic                           stop;
  logic                           sample_valid;
  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample_in;
  // Output stream: a word transfers on a cycle where out_valid && out_ready;
  // once raised, out_valid stays high and out_data stays stable until accepted.
  logic [4*(NUM_CH+1)-1:0]        out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           busy;
  logic                           done;
  logic [15:0]                    drop_cnt;
  logic [1:0]                     dbg_state;

  modport slave (
    input  start, stop, sample_valid, sample_in, out_ready,
    output out_data, out_valid, busy, done, drop_cnt, dbg_state
  );

  modport master (
    output start, stop, sample_valid, sample_in, out_ready,
    input  out_data, out_valid, busy, done, drop_cnt, dbg_state
  );
endinterface

// File: rtl/post_process_packer.sv
// Block capture of NUM_CH-channel samples, drained as marker-tagged nibble words.
// Optional macro PP_TRAILER_EN appends a drop-count trailer word to the final block.
module post_process_packer #(
  parameter int          NUM_CH       = 3,
  parameter int          SAMPLE_WIDTH = 16,
  parameter int          DEPTH        = 256,
  parameter logic [3:0]  MARKER       = 4'hF
) (
  input logic                clk,
  input logic                rst,
  post_process_packer_if.slave pp
);
  localparam int NIB = SAMPLE_WIDTH / 4;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int DW  = NUM_CH * SAMPLE_WIDTH;
  localparam int OW  = 4 * (NUM_CH + 1);
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_cnt;
  logic [NW-1:0]   nib_idx;
  logic            last_block;
  logic            cur_vld;
  logic [DW-1:0]   cur;
  logic [DW-1:0]   mem [DEPTH];
  logic [OW-1:0]   pack_word;

  logic out_free, load_word, cur_last, cur_free, rd_en, wr_en, data_done, last_now, drain_end;

  assign pp.dbg_state = state;

  // cur is the registered memory read port; it doubles as the sample being split into words.
  assign out_free  = !pp.out_valid || pp.out_ready;
  assign cur_last  = (nib_idx == NIB_LAST);
  assign load_word = (state == S_DRAIN) && cur_vld && out_free;
  assign cur_free  = !cur_vld || (load_word && cur_last);
  assign rd_en     = (state == S_DRAIN) && cur_free && (rd_cnt != wr_cnt);
  assign wr_en     = (state == S_FILL) && pp.sample_valid;
  assign data_done = (rd_cnt == wr_cnt) && !cur_vld;
  assign last_now  = last_block || pp.stop;

`ifdef PP_TRAILER_EN
  localparam int TW = 4 * NUM_CH;
  localparam logic [31:0] TRL_MAX = (32'd1 << TW) - 32'd1;
  logic          trl_sent;
  logic          load_trl;
  logic [TW-1:0] trl_val;
  assign trl_val   = ({16'd0, pp.drop_cnt} > TRL_MAX) ? TRL_MAX[TW-1:0] : TW'(pp.drop_cnt);
  assign load_trl  = (state == S_DRAIN) && data_done && last_now && !trl_sent && out_free;
  assign drain_end = (state == S_DRAIN) && data_done && pp.out_valid && pp.out_ready &&
                     (trl_sent || !last_now);
`else
  assign drain_end = (state == S_DRAIN) && data_done && pp.out_valid && pp.out_ready;
`endif

  // Word k: marker, then nibble k of ch0 .. ch(NUM_CH-1), MS nibble group first.
  always_comb begin
    pack_word = '0;
    pack_word[OW-1 -: 4] = MARKER;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pack_word[4*(NUM_CH-1-ch) +: 4] =
        cur[ch*SAMPLE_WIDTH + SAMPLE_WIDTH - 4 - 4*int'(nib_idx) +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= pp.sample_in;
    if (rd_en) cur <= mem[rd_cnt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      nib_idx      <= '0;
      last_block   <= 1'b0;
      cur_vld      <= 1'b0;
      pp.out_valid <= 1'b0;
      pp.out_data  <= '0;
      pp.busy      <= 1'b0;
      pp.done      <= 1'b0;
      pp.drop_cnt  <= '0;
`ifdef PP_TRAILER_EN
      trl_sent     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          wr_cnt      <= '0;
          drop_cnt_clear();
          pp.done     <= 1'b0;
          last_block  <= 1'b0;
          if (pp.start) begin
            state   <= S_FILL;
            pp.busy <= 1'b1;
          end
        end
        S_FILL: begin
          rd_cnt  <= '0;
          nib_idx <= '0;
          cur_vld <= 1'b0;
`ifdef PP_TRAILER_EN
          trl_sent <= 1'b0;
`endif
          if (pp.sample_valid) wr_cnt <= wr_cnt + 1'b1;
          if (pp.stop) begin
`ifndef PP_TRAILER_EN
            if (wr_cnt == '0 && !pp.sample_valid) begin
              state   <= S_DONE;
              pp.busy <= 1'b0;
              pp.done <= 1'b1;
            end else
`endif
            begin
              state      <= S_DRAIN;
              last_block <= 1'b1;
            end
          end else if (pp.sample_valid && wr_cnt == LAST_ADDR) begin
            state      <= S_DRAIN;
            last_block <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (pp.sample_valid && pp.drop_cnt != 16'hFFFF) pp.drop_cnt <= pp.drop_cnt + 1'b1;
          if (pp.stop) last_block <= 1'b1;
          if (rd_en) begin
            rd_cnt  <= rd_cnt + 1'b1;
            cur_vld <= 1'b1;
          end else if (load_word && cur_last) begin
            cur_vld <= 1'b0;
          end
          if (load_word) begin
            pp.out_data  <= pack_word;
            pp.out_valid <= 1'b1;
            nib_idx      <= cur_last ? '0 : nib_idx + 1'b1;
          end
`ifdef PP_TRAILER_EN
          else if (load_trl) begin
            pp.out_data  <= {4'h0, trl_val};
            pp.out_valid <= 1'b1;
            trl_sent     <= 1'b1;
          end
`endif
          else if (pp.out_valid && pp.out_ready) begin
            pp.out_valid <= 1'b0;
          end
          if (drain_end) begin
            pp.out_valid <= 1'b0;
            rd_cnt       <= '0;
            if (last_now) begin
              state   <= S_DONE;
              pp.busy <= 1'b0;
              pp.done <= 1'b1;
            end else begin
              state  <= S_FILL;
              wr_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          pp.out_valid <= 1'b0;
          pp.busy      <= 1'b0;
          pp.done      <= 1'b1;
          if (pp.start) begin
            state      <= S_FILL;
            pp.done    <= 1'b0;
            drop_cnt_clear();
            wr_cnt     <= '0;
            last_block <= 1'b0;
            pp.busy    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  task automatic drop_cnt_clear();
    pp.drop_cnt <= '0;
  endtask
endmodule

// File: tb/tb_post_process_packer.sv
// Directed bench for post_process_packer (NUM_CH=3, SAMPLE_WIDTH=16, DEPTH=4)
// with a word-queue model of the drained stream.
module tb_post_process_packer;
  localparam int NUM_CH = 3;
  localparam int SW     = 16;
  localparam int DEPTH  = 4;
  localparam int NIB    = SW / 4;
  localparam int DW     = NUM_CH * SW;
  localparam int OW     = 4 * (NUM_CH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  post_process_packer_if #(.NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW)) dut_if ();

  post_process_packer #(
    .NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .MARKER(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pp (dut_if)
  );

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data  = '0;

  logic [DW-1:0] samp_tab [0:3] = '{48'h0FED_3456_1234, 48'hA5C3_0001_FFFF,
                                    48'h8000_7FFF_C0DE, 48'h1357_2468_9ABC};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: each captured sample yields NIB words; word k carries nibble k of every channel.
  function automatic void push_sample(input logic [DW-1:0] s);
    for (int k = 0; k < NIB; k++) begin
      logic [63:0] w;
      w = 64'hF << (4 * NUM_CH);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        logic [63:0] chv, nib;
        chv = (64'(s) >> (ch * SW)) & 64'hFFFF;
        nib = (chv >> (SW - 4 - 4 * k)) & 64'hF;
        w   = w | (nib << (4 * (NUM_CH - 1 - ch)));
      end
      exp_q.push_back(w[OW-1:0]);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(dut_if.out_valid), 64'd1);
        check("stall_data", 64'(dut_if.out_data), 64'(prev_data));
      end
      if (dut_if.out_valid && dut_if.out_ready) begin
        hs_cnt <= hs_cnt + 1;
        got_q.push_back(dut_if.out_data);
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("word", 64'(dut_if.out_data), 64'(exp_q.pop_front()));
      end
      prev_stall <= dut_if.out_valid && !dut_if.out_ready;
      prev_data  <= dut_if.out_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    dut_if.start = 1'b1; tick(); dut_if.start = 1'b0;
  endtask

  task automatic pulse_stop();
    dut_if.stop = 1'b1; tick(); dut_if.stop = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] s, input bit with_stop, input bit captured);
    dut_if.sample_valid = 1'b1;
    dut_if.sample_in    = s;
    dut_if.stop         = with_stop;
    if (captured) push_sample(s);
    tick();
    dut_if.sample_valid = 1'b0;
    dut_if.stop         = 1'b0;
  endtask

  task automatic wait_drain(input string name, input bit want_done);
    int n = 0;
    while (!(exp_q.size() == 0 && (!want_done || dut_if.done)) && n <= 500) begin
      tick();
      n++;
    end
    check(name, 64'(n > 500), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    dut_if.start = 1'b0; dut_if.stop = 1'b0; dut_if.sample_valid = 1'b0;
    dut_if.sample_in = '0; dut_if.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
    check("rst_out_data", 64'(dut_if.out_data), 64'd0);
    check("rst_busy", 64'(dut_if.busy), 64'd0);
    check("rst_done", 64'(dut_if.done), 64'd0);
    check("rst_drop_cnt", 64'(dut_if.drop_cnt), 64'd0);

    // Test 1: full block, continuous ready
    pulse_start();
    @(negedge clk);
    check("t1_busy_fill", 64'(dut_if.busy), 64'd1);
    base = hs_cnt; got_q.delete();
    for (int i = 0; i < 4; i++) send(samp_tab[i], 1'b0, 1'b1);
    @(negedge clk); check("t1_lat_c1", 64'(dut_if.out_valid), 64'd0);
    @(negedge clk); check("t1_lat_c2", 64'(dut_if.out_valid), 64'd0);
    @(negedge clk); check("t1_lat_c3", 64'(dut_if.out_valid), 64'd1);
    wait_drain("t1_drain_timeout", 1'b0);
    check("t1_words", 64'(hs_cnt - base), 64'd16);
    check("t1_got_size", 64'(got_q.size()), 64'd16);
    if (got_q.size() >= 4) begin
      check("t1_lit_w0", 64'(got_q[0]), 64'hF130);
      check("t1_lit_w1", 64'(got_q[1]), 64'hF24F);
      check("t1_lit_w2", 64'(got_q[2]), 64'hF35E);
      check("t1_lit_w3", 64'(got_q[3]), 64'hF46D);
    end
    check("t1_busy_refill", 64'(dut_if.busy), 64'd1);
    check("t1_done", 64'(dut_if.done), 64'd0);

    // Test 2: partial block then stop
    base = hs_cnt;
    for (int i = 0; i < 2; i++) send(samp_tab[i] + 48'h0101_0101_0101, 1'b0, 1'b1);
    pulse_stop();
`ifdef PP_TRAILER_EN
    exp_q.push_back(16'h0000);
`endif
    wait_drain("t2_drain_timeout", 1'b1);
`ifdef PP_TRAILER_EN
    check("t2_words", 64'(hs_cnt - base), 64'd9);
`else
    check("t2_words", 64'(hs_cnt - base), 64'd8);
`endif
    check("t2_done", 64'(dut_if.done), 64'd1);
    check("t2_busy", 64'(dut_if.busy), 64'd0);
    check("t2_out_valid", 64'(dut_if.out_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_done_hold", 64'(dut_if.done), 64'd1);
    end
    pulse_start();
    @(negedge clk);
    check("t2_restart_done", 64'(dut_if.done), 64'd0);
    check("t2_restart_busy", 64'(dut_if.busy), 64'd1);

    // Test 3: ready toggling every cycle
    base = hs_cnt;
    for (int i = 0; i < 4; i++) send(samp_tab[i] ^ 48'h1111_2222_3333, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      dut_if.out_ready = ~dut_if.out_ready;
      tick();
      n++;
    end
    check("t3_toggle_timeout", 64'(n >= 400), 64'd0);
    dut_if.out_ready = 1'b1;
    tick();
    check("t3_words", 64'(hs_cnt - base), 64'd16);

    // Test 4: samples arriving during drain are dropped
    for (int i = 0; i < 4; i++) send(samp_tab[3-i], 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(48'hDEAD_BEEF_0000 + 48'(i), 1'b0, 1'b0);
    wait_drain("t4_drain_timeout", 1'b0);
    check("t4_drop_cnt", 64'(dut_if.drop_cnt), 64'd5);
    check("t4_busy", 64'(dut_if.busy), 64'd1);

    // Test 5: stop with the block-filling sample, then stop on an empty block
    base = hs_cnt;
    for (int i = 0; i < 3; i++) send(samp_tab[i] + 48'h0F0F_0F0F_0F0F, 1'b0, 1'b1);
    send(48'h0123_4567_89AB, 1'b1, 1'b1);
`ifdef PP_TRAILER_EN
    exp_q.push_back(16'h0005);
`endif
    wait_drain("t5_drain_timeout", 1'b1);
`ifdef PP_TRAILER_EN
    check("t5_words", 64'(hs_cnt - base), 64'd17);
`else
    check("t5_words", 64'(hs_cnt - base), 64'd16);
`endif
    check("t5_done", 64'(dut_if.done), 64'd1);
    check("t5_busy", 64'(dut_if.busy), 64'd0);
    check("t5_drop_kept", 64'(dut_if.drop_cnt), 64'd5);
    pulse_start();
    base = hs_cnt;
    pulse_stop();
`ifdef PP_TRAILER_EN
    exp_q.push_back(16'h0000);
    wait_drain("t5_empty_timeout", 1'b1);
    check("t5_empty_words", 64'(hs_cnt - base), 64'd1);
`else
    @(negedge clk);
    check("t5_empty_done", 64'(dut_if.done), 64'd1);
    check("t5_empty_busy", 64'(dut_if.busy), 64'd0);
    check("t5_empty_words", 64'(hs_cnt - base), 64'd0);
`endif
    check("t5_empty_drop", 64'(dut_if.drop_cnt), 64'd0);

    // Test 6: reset mid-drain, then a fresh capture
    pulse_start();
    base = hs_cnt;
    for (int i = 0; i < 4; i++) send(samp_tab[i], 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) send(48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    n = 0;
    while (hs_cnt - base < 5 && n < 100) begin
      tick();
      n++;
    end
    check("t6_wait_timeout", 64'(n >= 100), 64'd0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_out_valid", 64'(dut_if.out_valid), 64'd0);
    check("t6_busy", 64'(dut_if.busy), 64'd0);
    check("t6_drop_cnt", 64'(dut_if.drop_cnt), 64'd0);
    check("t6_done", 64'(dut_if.done), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    pulse_start();
    base = hs_cnt; got_q.delete();
    for (int i = 0; i < 4; i++) send(samp_tab[i], 1'b0, 1'b1);
    wait_drain("t6_drain_timeout", 1'b0);
    check("t6_words", 64'(hs_cnt - base), 64'd16);
    if (got_q.size() >= 1) check("t6_lit_w0", 64'(got_q[0]), 64'hF130);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/post_process_packer.md
Name: post_process_packer

Overview:
- Parametrised successor to the 3-channel UART post-processor.
- Captures NUM_CH-channel samples into an internal block of DEPTH samples, ping-ponging between fill and drain phases.
- Drains each sample as marker-tagged nibble words over a valid/ready stream to the UART serialiser.
- Supports a stop-triggered partial-block flush, dropped-sample accounting and a sticky done flag.

Parameters:
- NUM_CH, 3: channels per sample, 1..7.
- SAMPLE_WIDTH, 16: bits per channel sample; must be a multiple of 4 (12 or 16 typical). NIB = SAMPLE_WIDTH/4.
- DEPTH, 256: samples per block; power of two, >= 2.
- MARKER, 4'hF: nibble placed in the MS position of every data word.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin capture; honoured only in IDLE or DONE.
- stop  in  1  end of capture; flushes the partial block and then finishes.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_in  in  NUM_CH*SAMPLE_WIDTH  channel 0 in the LS slice.
- out_data  out  4*(NUM_CH+1)  packed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- busy  out  1  high in FILL or DRAIN.
- done  out  1  sticky end-of-capture flag.
- drop_cnt  out  16  samples dropped during DRAIN; saturating.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; wr_cnt=0; rd_cnt=0; nib_idx=0; last_block=0; out_valid=0; out_data=0; busy=0; done=0; drop_cnt=0. Reset mid-operation aborts immediately. Memory contents are don't-care.
- IDLE:
  - start -> FILL.
  - Clears wr_cnt, drop_cnt, done and last_block.
- FILL:
  - sample_valid writes mem[wr_cnt] <= sample_in and increments wr_cnt.
  - If the write makes wr_cnt==DEPTH -> DRAIN with last_block=0.
  - stop (with or without a same-cycle write, the write taking effect first) -> DRAIN with last_block=1.
  - If stop arrives with wr_cnt==0 and no same-cycle write -> DONE directly.
  - A sample filling the block in the same cycle as stop -> DRAIN with last_block=1.
- DRAIN:
  - Reads samples 0..wr_cnt-1 in order. Each sample yields NIB words, MS nibble group first.
  - Word k of sample s = {MARKER, ch0 nibble k, ch1 nibble k, ..., ch(NUM_CH-1) nibble k}. Nibble k = bits [SAMPLE_WIDTH-1-4k -: 4].
  - Synchronous memory read: first out_valid rises 2 cycles after entering DRAIN.
  - While out_valid && !out_ready, out_data is held stable.
  - Steady-state throughput is one word per cycle while out_ready=1.
  - sample_valid in DRAIN: the sample is discarded and drop_cnt increments, saturating at 16'hFFFF.
  - stop in DRAIN sets last_block=1.
  - After the final word is accepted: if last_block -> DONE, else -> FILL with wr_cnt=0 and rd_cnt=0.
  - start is ignored.
- DONE:
  - done=1, busy=0, out_valid=0.
  - Holds until start (-> FILL; clears done, drop_cnt and wr_cnt) or rst.
- Counter widths: wr_cnt and rd_cnt are clog2(DEPTH)+1 bits; nib_idx is clog2(NIB) bits. Internally, no wrap-around is permitted.

Optional Feature:
- Macro: PP_TRAILER_EN.
- Defined: after the last data word of the final block (last_block=1), one extra word {4'h0, drop_cnt saturated to 4*NUM_CH bits} is emitted under the same handshake before DONE. A stop with zero samples also emits the trailer.
- Undefined: no trailer; the behaviour is exactly as above.

Test Plan:
1. NUM_CH=3, SAMPLE_WIDTH=16, DEPTH=4. start; 4 samples {ch2,ch1,ch0}={16'h0FED,16'h3456,16'h1234}...; out_ready=1 -> 16 words, first three 16'hF130, 16'hF24F, 16'hF35E; the block returns to FILL; done=0.
2. Same config: 2 samples, then stop -> 8 words emitted, then done=1 and busy=0; done holds for 10 cycles until start.
3. out_ready toggled 1/0 every cycle during DRAIN -> no word lost or duplicated; out_data stable while stalled; 16 handshakes total.
4. sample_valid held high for 5 cycles during DRAIN -> drop_cnt=5; no memory corruption (drained words match the captured block).
5. stop together with the sample that fills the block (4th) -> 16 words, then DONE; also stop with wr_cnt=0 -> DONE next cycle with no words (PP_TRAILER_EN: one word 16'h0000 when no drops).
6. rst asserted mid-DRAIN after 5 words -> next cycle out_valid=0, busy=0, drop_cnt=0; a fresh start and capture behaves as in test 1.
